dm_param_pp: RTL

DM_PARAM_PP -- requirements
Module: dm_param_pp

---
 rtl/dm_param_pp.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/dm_param_pp.sv
// dm_param_pp: single-port word memory with per-bit write mask.
// After reset the array is swept to zero one word per clock (CLEAR), then
// requests are accepted (RUN). Reads have one cycle of latency; addresses at
// or above DEPTH are flagged with a one-cycle oor pulse and read back as zero.
// Optional macro DM_WR_FWD_EN: a read and write in the same cycle return the
// merged new word (write-first); without it the pre-write word is returned.
module dm_param_pp #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] dataw,
  input  logic [DATA_W-1:0] wmask,
  input  logic              read,
  input  logic              write,
  output logic [DATA_W-1:0] data,
  output logic              rvalid,
  output logic              ready,
  output logic              oor
);

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  // One extra bit so DEPTH == 2**ADDR_W is representable in the range check.
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_W  = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                rvalid_q, rvalid_d;
  logic                oor_q, oor_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                ready_c;
  logic                in_range;
  logic                accept;
  logic [DATA_W-1:0]   cur_word;
  logic [DATA_W-1:0]   merged;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  // State, clear counter and output registers; reset drops everything to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= CLEAR;
      cnt_q    <= '0;
      data_q   <= '0;
      rvalid_q <= 1'b0;
      oor_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      rvalid_q <= rvalid_d;
      oor_q    <= oor_d;
    end
  end

  // Next state: sweep cnt through every word, leave CLEAR on the last one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        if (cnt_q == LAST_W) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // FSM outputs: requests are only accepted in RUN.
  always_comb begin
    ready_c = (state_q == RUN);
  end

  // Request decode and masked merge of the addressed word.
  always_comb begin
    in_range = ({1'b0, addr} < DEPTH_L);
    accept   = ready_c && (read || write);
    cur_word = in_range ? mem_q[addr] : '0;
    merged   = (cur_word & ~wmask) | (dataw & wmask);
  end

  // Memory write port: clearing sweep in CLEAR, masked request write in RUN.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = merged;
    if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = '0;
    end else if (write && in_range) begin
      mem_we = 1'b1;
    end
  end

  // Read response: data holds unless a read is accepted; out-of-range reads return 0.
  always_comb begin
    rvalid_d = accept && read;
    oor_d    = accept && !in_range;
    data_d   = data_q;
    if (accept && read) begin
      if (!in_range) begin
        data_d = '0;
      end else begin
`ifdef DM_WR_FWD_EN
        data_d = write ? merged : cur_word;
`else
        data_d = cur_word;
`endif
      end
    end
  end

  // Storage array; contents are defined only once the clearing sweep finishes.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign data   = data_q;
  assign rvalid = rvalid_q;
  assign ready  = ready_c;
  assign oor    = oor_q;

endmodule
